uart_tx_framer: RTL
===================

Name: uart_tx_framer

Overview:
- Parametrised UART transmitter with an internal baud divider and a one-word holding register, so back-to-back frames go out with no idle gap.
- Data width is set at build time; parity mode and stop-bit count are runtime inputs, captured per frame.
- Sits between a byte-stream producer (valid/ready) and the TX pad; it is the transmit counterpart to the team's UART receiver.

Parameters:
- p_CLK_FREQUENCY, 12000000: i_clk frequency in Hz.
- p_BAUD_RATE, 115200: line rate. lp_DIV = p_CLK_FREQUENCY / p_BAUD_RATE (integer division) must be >= 2; elaboration error otherwise.
- p_DATA_BITS, 8: data bits per frame, legal range 5..9, sent LSB first.

Ports:
- i_clk  in  1  clock, rising-edge.
- i_reset_n  in  1  asynchronous active-low reset.
- iv_data  in  p_DATA_BITS  word to send.
- i_valid  in  1  iv_data is valid.
- o_ready  out  1  holding register is empty; a transfer occurs on an edge where i_valid & o_ready.
- iv_parity_mode  in  2  00 none, 01 even, 10 odd, 11 mark (parity bit always 1).
- i_two_stop  in  1  0 = one stop bit, 1 = two stop bits.
- o_output  out  1  serial line, idle high; registered.
- o_busy  out  1  frame in flight or holding register full.
- o_frame_done  out  1  one-cycle pulse at the end of each frame's last stop bit.

Behaviour:
- Reset (asynchronous, active-low):
  - o_output=1, o_ready=1, o_busy=0, o_frame_done=0.
  - Holding register cleared; state IDLE; baud and bit counters 0.
  - Reset mid-frame aborts the frame immediately. The line returns high asynchronously. No o_frame_done is generated.
- Holding register:
  - Accepts at edge E0 when i_valid & o_ready.
  - o_ready is low from after E0 until the word moves to the shifter.
  - i_valid with o_ready low is ignored; data is not captured.
- Load:
  - At any edge where the shifter is IDLE and the holding register is full, the shifter loads the data.
  - At the same edge it latches iv_parity_mode and i_two_stop. These are sampled at load time, not at acceptance.
  - It enters START and o_ready rises.
  - From an idle shifter, the start bit appears on o_output after E1 (one cycle after acceptance).
  - Changes to the config inputs mid-frame have no effect on the current frame.
- Baud counter:
  - Counts 0..lp_DIV-1 only while state != IDLE; reset to 0 on load.
  - Each bit lasts exactly lp_DIV cycles. The bit ends on the edge where the counter equals lp_DIV-1.
- State machine:
  - IDLE: o_output=1.
  - START: o_output=0, one bit time -> DATA.
  - DATA: o_output = data[k], k = 0..p_DATA_BITS-1. After the last bit -> PARITY if mode != 00, else STOP.
  - PARITY: even = XOR of the data; odd = inverted XOR; mark = 1. One bit time -> STOP.
  - STOP: o_output=1 for 1 or 2 bit times according to the latched i_two_stop.
- End of final stop bit (same edge):
  - o_frame_done pulses for the following cycle.
  - If the holding register is full, load it and go directly to START: the next start bit immediately follows, zero idle cycles.
  - Otherwise go to IDLE.
- Simultaneous events:
  - Acceptance on the same edge as end-of-frame with the holding register empty: the word enters the holding register. It loads on the next edge, so exactly one idle-high cycle appears.
  - Acceptance and load on the same edge cannot coincide, because o_ready=0 whenever the holding register is full.
- Frame length in cycles: lp_DIV * (1 + p_DATA_BITS + (mode != 00) + (i_two_stop ? 2 : 1)).
- o_busy = (state != IDLE) | holding register full.

Test Plan (p_CLK_FREQUENCY=1000, p_BAUD_RATE=100 so lp_DIV=10; p_DATA_BITS=8 unless stated):
- 8N1, iv_data=0xA5 -> o_output bits 0,1,0,1,0,0,1,0,1,1, each 10 cycles. Start bit begins 1 cycle after acceptance. o_frame_done pulses once, 100 cycles after the start bit begins. o_busy drops with it.
- Parity: 0xA5 with mode=01 -> parity bit 0; mode=10 -> 1; mode=11 -> 1; 0x01 with mode=01 -> 1. Frame is 110 cycles.
- Back-to-back: 0x55 then 0x0F, i_valid held high.
  - Second word is accepted 1 cycle after the first loads.
  - Second start bit begins on the cycle right after the first frame's stop bit, with no high gap.
  - o_ready stays low until the second load.
- i_two_stop=1, mode=00, 0xFF -> stop high for 20 cycles, frame 110 cycles.
  - Toggling i_two_stop and iv_parity_mode mid-frame does not alter the frame.
  - A word queued during that frame uses the config present at its load edge.
- Reset asserted mid-DATA -> o_output=1 immediately; no o_frame_done. After release, o_ready=1 and a new 0x3C frame transmits correctly.
- p_DATA_BITS=7, 0x7F, mode=10 -> 7 ones, parity 0, one stop bit; frame 100 cycles.

Source files
------------

// File: rtl/uart_tx_framer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_framer : UART transmitter, internal baud divider, one-word holding
//                  register for gap-free back-to-back frames.
// Revision       : 1.0
// ---------------------------------------------------------------------------
module uart_tx_framer #(
  parameter int p_CLK_FREQUENCY = 12000000,
  parameter int p_BAUD_RATE     = 115200,
  parameter int p_DATA_BITS     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [p_DATA_BITS-1:0] iv_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [1:0]             iv_parity_mode,
  input  logic                   i_two_stop,
  output logic                   o_output,
  output logic                   o_busy,
  output logic                   o_frame_done
);

  localparam int lp_DIV   = p_CLK_FREQUENCY / p_BAUD_RATE;
  localparam int c_CNT_W  = (lp_DIV > 1) ? $clog2(lp_DIV) : 1;
  localparam int c_BIT_W  = $clog2(p_DATA_BITS);

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(lp_DIV - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(p_DATA_BITS - 1);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_START  = 3'd1;
  localparam logic [2:0] c_ST_DATA   = 3'd2;
  localparam logic [2:0] c_ST_PARITY = 3'd3;
  localparam logic [2:0] c_ST_STOP   = 3'd4;

  if (lp_DIV < 2) begin : g_div_check
    $error("uart_tx_framer: clock/baud ratio must be at least 2");
  end

  if ((p_DATA_BITS < 5) || (p_DATA_BITS > 9)) begin : g_width_check
    $error("uart_tx_framer: p_DATA_BITS must be in 5..9");
  end

  logic [2:0]             r_state;
  logic [c_CNT_W-1:0]     r_baud_cnt;
  logic [c_BIT_W-1:0]     r_bit_cnt;
  logic [p_DATA_BITS-1:0] r_shift;
  logic [p_DATA_BITS-1:0] r_hold_data;
  logic                   r_hold_full;
  logic [1:0]             r_parity_mode;
  logic                   r_two_stop;
  logic                   r_parity_bit;
  logic                   r_output;
  logic                   r_frame_done;

  logic [2:0]             w_state_next;
  logic [c_BIT_W-1:0]     w_bit_cnt_next;
  logic                   w_bit_end;
  logic                   w_load;
  logic                   w_frame_end;
  logic                   w_shift_en;
  logic                   w_accept;
  logic                   w_parity_calc;
  logic [p_DATA_BITS-1:0] w_shift_next;
  logic                   w_output_next;

  assign w_bit_end = (r_state != c_ST_IDLE) && (r_baud_cnt == c_CNT_LAST);

  // State register plus all datapath registers that follow the FSM.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= c_ST_IDLE;
      r_baud_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_hold_data   <= '0;
      r_hold_full   <= 1'b0;
      r_parity_mode <= 2'b00;
      r_two_stop    <= 1'b0;
      r_parity_bit  <= 1'b0;
      r_output      <= 1'b1;
      r_frame_done  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_shift      <= w_shift_next;
      r_output     <= w_output_next;
      r_frame_done <= w_frame_end;

      if (w_load) begin
        r_baud_cnt <= '0;
      end else if (r_state != c_ST_IDLE) begin
        r_baud_cnt <= (r_baud_cnt == c_CNT_LAST) ? '0 : r_baud_cnt + c_CNT_W'(1);
      end

      if (w_accept) begin
        r_hold_data <= iv_data;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end

      // Frame configuration is taken at load, not at acceptance.
      if (w_load) begin
        r_parity_mode <= iv_parity_mode;
        r_two_stop    <= i_two_stop;
        r_parity_bit  <= w_parity_calc;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_load         = 1'b0;
    w_frame_end    = 1'b0;
    w_shift_en     = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (r_hold_full) begin
          w_load       = 1'b1;
          w_state_next = c_ST_START;
        end
      end
      c_ST_START: begin
        if (w_bit_end) begin
          w_state_next   = c_ST_DATA;
          w_bit_cnt_next = '0;
        end
      end
      c_ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == c_BIT_LAST) begin
            w_bit_cnt_next = '0;
            w_state_next   = (r_parity_mode != 2'b00) ? c_ST_PARITY : c_ST_STOP;
          end else begin
            w_bit_cnt_next = r_bit_cnt + c_BIT_W'(1);
            w_shift_en     = 1'b1;
          end
        end
      end
      c_ST_PARITY: begin
        if (w_bit_end) begin
          w_state_next   = c_ST_STOP;
          w_bit_cnt_next = '0;
        end
      end
      c_ST_STOP: begin
        if (w_bit_end) begin
          if (r_two_stop && (r_bit_cnt == '0)) begin
            w_bit_cnt_next = c_BIT_W'(1);
          end else begin
            // Reloading here keeps consecutive frames free of idle cycles.
            w_frame_end    = 1'b1;
            w_bit_cnt_next = '0;
            if (r_hold_full) begin
              w_load       = 1'b1;
              w_state_next = c_ST_START;
            end else begin
              w_state_next = c_ST_IDLE;
            end
          end
        end
      end
      default: begin
        w_state_next   = c_ST_IDLE;
        w_bit_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    w_accept = i_valid & ~r_hold_full;

    case (iv_parity_mode)
      2'b01:   w_parity_calc = ^r_hold_data;
      2'b10:   w_parity_calc = ~(^r_hold_data);
      default: w_parity_calc = 1'b1;
    endcase

    if (w_load) begin
      w_shift_next = r_hold_data;
    end else if (w_shift_en) begin
      w_shift_next = r_shift >> 1;
    end else begin
      w_shift_next = r_shift;
    end

    // The line register is driven from the upcoming state so it changes on the same edge.
    case (w_state_next)
      c_ST_START:  w_output_next = 1'b0;
      c_ST_DATA:   w_output_next = w_shift_next[0];
      c_ST_PARITY: w_output_next = r_parity_bit;
      default:     w_output_next = 1'b1;
    endcase

    o_ready      = ~r_hold_full;
    o_busy       = (r_state != c_ST_IDLE) | r_hold_full;
    o_output     = r_output;
    o_frame_done = r_frame_done;
  end

endmodule
`default_nettype wire
